// File: rtl/gpu_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// gpu_cmd_dispatcher - pops raster commands, latches operands, strobes the
// selected engine and waits for its done under a watchdog.   Rev 1.0
// ============================================================================
module gpu_cmd_dispatcher #(
  parameter int WIDTH_BITS     = 10,
  parameter int HEIGHT_BITS    = 9,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_BITS     = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   cmd_valid_i,
  input  logic [3:0]             opcode_i,
  input  logic [WIDTH_BITS-1:0]  x1_i,
  input  logic [HEIGHT_BITS-1:0] y1_i,
  input  logic [WIDTH_BITS-1:0]  x2_i,
  input  logic [HEIGHT_BITS-1:0] y2_i,
  input  logic [WIDTH_BITS-1:0]  rad_i,
  input  logic [2:0]             oct_i,
  input  logic                   done_line_i,
  input  logic                   done_fill_i,
  input  logic                   done_arc_i,
  output logic                   pop_o,
  output logic                   run_line_o,
  output logic                   run_fill_o,
  output logic                   run_arc_o,
  output logic [WIDTH_BITS-1:0]  x1_o,
  output logic [HEIGHT_BITS-1:0] y1_o,
  output logic [WIDTH_BITS-1:0]  x2_o,
  output logic [HEIGHT_BITS-1:0] y2_o,
  output logic [WIDTH_BITS-1:0]  rad_o,
  output logic [2:0]             oct_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   timeout_o,
  output logic [COUNT_BITS-1:0]  cmd_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LINE  = 4'b0100;
  localparam logic [3:0] OP_FILL  = 4'b0101;
  localparam logic [3:0] OP_CLEAR = 4'b0110;
  localparam logic [3:0] OP_ARC   = 4'b0111;

  // Engine select, one-hot in the order {arc, fill, line}
  localparam logic [2:0] ENG_NONE = 3'b000;
  localparam logic [2:0] ENG_LINE = 3'b001;
  localparam logic [2:0] ENG_FILL = 3'b010;
  localparam logic [2:0] ENG_ARC  = 3'b100;

  localparam int  WD_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit  WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_BITS-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_BITS'(TIMEOUT_CYCLES - 1) : {WD_BITS{1'b0}};

  localparam logic [WIDTH_BITS-1:0]  CLR_X2 = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] CLR_Y2 = HEIGHT_BITS'(SCREEN_H - 1);

  state_t                 state_q, state_d;
  logic [2:0]             eng_q, eng_d;
  logic                   pop_q, pop_d;
  logic [2:0]             run_q, run_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_BITS-1:0]  count_q, count_d;
  logic [WD_BITS-1:0]     wd_q, wd_d;
  logic [WIDTH_BITS-1:0]  x1_q, x1_d;
  logic [HEIGHT_BITS-1:0] y1_q, y1_d;
  logic [WIDTH_BITS-1:0]  x2_q, x2_d;
  logic [HEIGHT_BITS-1:0] y2_q, y2_d;
  logic [WIDTH_BITS-1:0]  rad_q, rad_d;
  logic [2:0]             oct_q, oct_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      eng_q     <= ENG_NONE;
      pop_q     <= 1'b0;
      run_q     <= 3'b000;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      wd_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      rad_q     <= '0;
      oct_q     <= '0;
    end else begin
      state_q   <= state_d;
      eng_q     <= eng_d;
      pop_q     <= pop_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      wd_q      <= wd_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      rad_q     <= rad_d;
      oct_q     <= oct_d;
    end
  end

  // Pulse outputs are computed one state ahead so they line up with ISSUE.
  always_comb begin
    state_d   = state_q;
    eng_d     = eng_q;
    pop_d     = 1'b0;
    run_d     = 3'b000;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    count_d   = count_q;
    wd_d      = wd_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    x2_d      = x2_q;
    y2_d      = y2_q;
    rad_d     = rad_q;
    oct_d     = oct_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_ISSUE;
          pop_d   = 1'b1;
          case (opcode_i)
            OP_LINE, OP_FILL: begin
              eng_d = (opcode_i == OP_LINE) ? ENG_LINE : ENG_FILL;
              x1_d  = x1_i;
              y1_d  = y1_i;
              x2_d  = x2_i;
              y2_d  = y2_i;
            end
            OP_CLEAR: begin
              eng_d = ENG_FILL;
              x1_d  = '0;
              y1_d  = '0;
              x2_d  = CLR_X2;
              y2_d  = CLR_Y2;
            end
            OP_ARC: begin
              // Arc centre arrives on the x2/y2 lanes of the FIFO entry
              eng_d = ENG_ARC;
              x1_d  = x2_i;
              y1_d  = y2_i;
              rad_d = rad_i;
              oct_d = oct_i;
            end
            OP_NOP: begin
              eng_d = ENG_NONE;
            end
            default: begin
              eng_d = ENG_NONE;
              err_d = 1'b1;
            end
          endcase
          run_d = eng_d;
        end
      end

      S_ISSUE: begin
        if (eng_q != ENG_NONE) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end else begin
          state_d = S_IDLE;
          if (!err_q) begin
            count_d = count_q + 1'b1;
          end
        end
      end

      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if ((eng_q & {done_arc_i, done_fill_i, done_line_i}) != 3'b000) begin
          state_d = S_IDLE;
          count_d = count_q + 1'b1;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign pop_o       = pop_q;
  assign run_line_o  = run_q[0];
  assign run_fill_o  = run_q[1];
  assign run_arc_o   = run_q[2];
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;
  assign cmd_count_o = count_q;
  assign x1_o        = x1_q;
  assign y1_o        = y1_q;
  assign x2_o        = x2_q;
  assign y2_o        = y2_q;
  assign rad_o       = rad_q;
  assign oct_o       = oct_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_dispatcher.sv
`default_nettype none
// Bench for gpu_cmd_dispatcher: directed scenarios plus randomized traffic,
// every cycle compared against a command-level reference model.
module tb_gpu_cmd_dispatcher;

  localparam int W  = 10;
  localparam int H  = 9;
  localparam int T  = 8;
  localparam int CB = 16;

  logic          clk;
  logic          n_rst;
  logic          cmd_valid_i;
  logic [3:0]    opcode_i;
  logic [W-1:0]  x1_i, x2_i, rad_i;
  logic [H-1:0]  y1_i, y2_i;
  logic [2:0]    oct_i;
  logic          done_line_i, done_fill_i, done_arc_i;
  logic          pop_o, run_line_o, run_fill_o, run_arc_o;
  logic [W-1:0]  x1_o, x2_o, rad_o;
  logic [H-1:0]  y1_o, y2_o;
  logic [2:0]    oct_o;
  logic          busy_o, err_o, timeout_o;
  logic [CB-1:0] cmd_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_cmd_dispatcher #(
    .WIDTH_BITS(W), .HEIGHT_BITS(H), .SCREEN_W(640), .SCREEN_H(480),
    .TIMEOUT_CYCLES(T), .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid_i(cmd_valid_i), .opcode_i(opcode_i),
    .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i), .rad_i(rad_i),
    .oct_i(oct_i), .done_line_i(done_line_i), .done_fill_i(done_fill_i),
    .done_arc_i(done_arc_i), .pop_o(pop_o), .run_line_o(run_line_o),
    .run_fill_o(run_fill_o), .run_arc_o(run_arc_o), .x1_o(x1_o), .y1_o(y1_o),
    .x2_o(x2_o), .y2_o(y2_o), .rad_o(rad_o), .oct_o(oct_o), .busy_o(busy_o),
    .err_o(err_o), .timeout_o(timeout_o), .cmd_count_o(cmd_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pop, run_line, run_fill, run_arc, busy, err, timeout}
  logic [6:0]  dut_ctl;
  logic [63:0] dut_ops;
  assign dut_ctl = {pop_o, run_line_o, run_fill_o, run_arc_o, busy_o, err_o, timeout_o};
  assign dut_ops = 64'({x1_o, y1_o, x2_o, y2_o, rad_o, oct_o});

  function automatic logic [63:0] ops(input int x1, input int y1, input int x2,
                                      input int y2, input int rad, input int oct);
    logic [W-1:0] a, c, r;
    logic [H-1:0] b, d;
    logic [2:0]   o;
    a = W'(x1); b = H'(y1); c = W'(x2); d = H'(y2); r = W'(rad); o = 3'(oct);
    return 64'({a, b, c, d, r, o});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one command in flight at a time, tracked by its age in
  // cycles since the pop (age 0 = pop cycle, age k>=1 = k-th wait cycle).
  typedef struct packed {
    logic          inflight;
    logic [31:0]   age;
    logic [1:0]    eng;      // 0 none, 1 line, 2 fill, 3 arc
    logic          nop;
    logic          pop, rl, rf, ra, err, to;
    logic [W-1:0]  x1;
    logic [H-1:0]  y1;
    logic [W-1:0]  x2;
    logic [H-1:0]  y2;
    logic [W-1:0]  rad;
    logic [2:0]    oct;
    logic [CB-1:0] count;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t c);
    mdl_t n;
    logic hit;
    n = c;
    n.pop = 0; n.rl = 0; n.rf = 0; n.ra = 0; n.err = 0; n.to = 0;
    if (!c.inflight) begin
      if (cmd_valid_i) begin
        n.inflight = 1; n.age = 0; n.pop = 1; n.nop = 0; n.eng = 0;
        case (opcode_i)
          4'h4, 4'h5: begin
            n.eng = (opcode_i == 4'h4) ? 2'd1 : 2'd2;
            n.x1 = x1_i; n.y1 = y1_i; n.x2 = x2_i; n.y2 = y2_i;
          end
          4'h6: begin
            n.eng = 2'd2; n.x1 = 0; n.y1 = 0; n.x2 = W'(639); n.y2 = H'(479);
          end
          4'h7: begin
            n.eng = 2'd3; n.x1 = x2_i; n.y1 = y2_i; n.rad = rad_i; n.oct = oct_i;
          end
          4'h0:    n.nop = 1;
          default: n.err = 1;
        endcase
        n.rl = (n.eng == 2'd1);
        n.rf = (n.eng == 2'd2);
        n.ra = (n.eng == 2'd3);
      end
    end else if (c.age == 0) begin
      if (c.eng == 2'd0) begin
        n.inflight = 0;
        if (c.nop) n.count = c.count + 1'b1;
      end else begin
        n.age = 1;
      end
    end else begin
      hit = (c.eng == 2'd1 && done_line_i) || (c.eng == 2'd2 && done_fill_i) ||
            (c.eng == 2'd3 && done_arc_i);
      if (hit) begin
        n.inflight = 0;
        n.count = c.count + 1'b1;
      end else if (c.age == 32'(T)) begin
        n.inflight = 0;
        n.to = 1;
      end else begin
        n.age = c.age + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m <= '0;
    else        m <= step(m);
  end

  always @(negedge clk) begin
    check("ctl",   64'(dut_ctl), 64'({m.pop, m.rl, m.rf, m.ra, m.inflight, m.err, m.to}));
    check("ops",   dut_ops, 64'({m.x1, m.y1, m.x2, m.y2, m.rad, m.oct}));
    check("count", 64'(cmd_count_o), 64'(m.count));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmd(input logic [3:0] op, input int x1, input int y1, input int x2,
                     input int y2, input int rad, input int oct);
    cmd_valid_i = 1'b1;
    opcode_i = op;
    x1_i = W'(x1); y1_i = H'(y1); x2_i = W'(x2); y2_i = H'(y2);
    rad_i = W'(rad); oct_i = 3'(oct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    cmd_valid_i = 1'b0; opcode_i = 4'h0;
    x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0; rad_i = '0; oct_i = '0;
    done_line_i = 1'b0; done_fill_i = 1'b0; done_arc_i = 1'b0;
    ticks(3);
    check("reset_ctl", 64'(dut_ctl), 64'd0);
    check("reset_ops", dut_ops, 64'd0);
    check("reset_count", 64'(cmd_count_o), 64'd0);
    n_rst = 1'b1;
    tick();

    // Line command, done five cycles after the run strobe
    cmd(4'b0100, 10, 20, 300, 200, 0, 0);
    tick();
    check("line_issue", 64'(dut_ctl), 64'b1100100);
    check("line_ops", dut_ops, ops(10, 20, 300, 200, 0, 0));
    cmd_valid_i = 1'b0;
    tick();
    check("line_wait", 64'(dut_ctl), 64'b0000100);
    ticks(3);
    done_line_i = 1'b1;
    tick();
    done_line_i = 1'b0;
    check("line_done_ctl", 64'(dut_ctl), 64'd0);
    check("line_done_count", 64'(cmd_count_o), 64'd1);

    // Clear screen with a stray line done during the wait
    cmd(4'b0110, 5, 6, 7, 8, 9, 1);
    tick();
    check("clear_issue", 64'(dut_ctl), 64'b1010100);
    check("clear_ops", dut_ops, ops(0, 0, 639, 479, 0, 0));
    cmd_valid_i = 1'b0;
    tick();
    done_line_i = 1'b1;
    tick();
    done_line_i = 1'b0;
    check("clear_stray_done", 64'(busy_o), 64'd1);
    done_fill_i = 1'b1;
    tick();
    done_fill_i = 1'b0;
    check("clear_done_ctl", 64'(dut_ctl), 64'd0);
    check("clear_done_count", 64'(cmd_count_o), 64'd2);

    // Arc: centre taken from x2/y2
    cmd(4'b0111, 1, 2, 100, 50, 30, 5);
    tick();
    check("arc_issue", 64'(dut_ctl), 64'b1001100);
    check("arc_ops", dut_ops, ops(100, 50, 639, 479, 30, 5));
    cmd_valid_i = 1'b0;
    tick();
    done_arc_i = 1'b1;
    tick();
    done_arc_i = 1'b0;
    check("arc_done_count", 64'(cmd_count_o), 64'd3);

    // Illegal then NOP, back to back
    cmd(4'b1111, 11, 12, 13, 14, 15, 2);
    tick();
    check("ill_issue", 64'(dut_ctl), 64'b1000110);
    opcode_i = 4'b0000;
    tick();
    check("ill_back_idle", 64'(dut_ctl), 64'd0);
    check("ill_no_count", 64'(cmd_count_o), 64'd3);
    tick();
    check("nop_issue", 64'(dut_ctl), 64'b1000100);
    check("nop_ops_held", dut_ops, ops(100, 50, 639, 479, 30, 5));
    cmd_valid_i = 1'b0;
    tick();
    check("nop_count", 64'(cmd_count_o), 64'd4);

    // Watchdog expiry, then done landing on the terminal wait cycle
    cmd(4'b0100, 1, 1, 2, 2, 0, 0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    ticks(7);
    check("wd_pre", 64'(dut_ctl), 64'b0000100);
    tick();
    check("wd_timeout", 64'(dut_ctl), 64'b0000001);
    check("wd_count", 64'(cmd_count_o), 64'd4);
    tick();
    check("wd_pulse_end", 64'(dut_ctl), 64'd0);
    cmd(4'b0100, 3, 3, 4, 4, 0, 0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    ticks(7);
    done_line_i = 1'b1;
    tick();
    done_line_i = 1'b0;
    check("wd_done_wins", 64'(dut_ctl), 64'd0);
    check("wd_done_count", 64'(cmd_count_o), 64'd5);

    // Reset in the middle of a wait
    cmd(4'b0101, 21, 22, 23, 24, 0, 0);
    tick();
    cmd_valid_i = 1'b0;
    ticks(2);
    n_rst = 1'b0;
    #1;
    check("arst_ctl", 64'(dut_ctl), 64'd0);
    check("arst_ops", dut_ops, 64'd0);
    check("arst_count", 64'(cmd_count_o), 64'd0);
    cmd(4'b0100, 7, 8, 9, 10, 0, 0);
    ticks(2);
    n_rst = 1'b1;
    tick();
    check("post_rst_issue", 64'(dut_ctl), 64'b1100100);
    check("post_rst_ops", dut_ops, ops(7, 8, 9, 10, 0, 0));
    cmd_valid_i = 1'b0;
    tick();
    done_line_i = 1'b1;
    tick();
    done_line_i = 1'b0;
    check("post_rst_count", 64'(cmd_count_o), 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      n_rst       = ($urandom_range(0, 399) != 0);
      cmd_valid_i = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       opcode_i = 4'h0;
        1:       opcode_i = 4'h4;
        2:       opcode_i = 4'h5;
        3:       opcode_i = 4'h6;
        4:       opcode_i = 4'h7;
        default: opcode_i = 4'($urandom_range(0, 15));
      endcase
      x1_i  = W'($urandom); y1_i = H'($urandom);
      x2_i  = W'($urandom); y2_i = H'($urandom);
      rad_i = W'($urandom); oct_i = 3'($urandom);
      done_line_i = ($urandom_range(0, 5) == 0);
      done_fill_i = ($urandom_range(0, 5) == 0);
      done_arc_i  = ($urandom_range(0, 5) == 0);
      tick();
    end

    n_rst = 1'b1;
    cmd_valid_i = 1'b0;
    done_line_i = 1'b0; done_fill_i = 1'b0; done_arc_i = 1'b0;
    ticks(12);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
